// File: rtl/mult_operand_sequencer.sv
// rtl/mult_operand_sequencer.sv - operand register and settle-timer front end for a combinational array multiplier
module mult_operand_sequencer #(
    parameter int INPUT_BIT_SIZE  = 32,
    parameter int OUTPUT_BIT_SIZE = 2 * INPUT_BIT_SIZE,
    parameter int SETTLE_CYCLES   = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    output logic                       InReady,
    input  logic [INPUT_BIT_SIZE-1:0]  OpA,
    input  logic [INPUT_BIT_SIZE-1:0]  OpB,
    output logic [INPUT_BIT_SIZE-1:0]  InA,
    output logic [INPUT_BIT_SIZE-1:0]  InB,
    input  logic [OUTPUT_BIT_SIZE-1:0] MultOut,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [OUTPUT_BIT_SIZE-1:0] Product,
    output logic                       Busy
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          capture;

    // Reset gates InReady so no pair looks accepted while the block is held in reset.
    assign InReady = Reset && ((state == IDLE) || ((state == HOLD) && OutReady));
    assign Busy    = (state != IDLE);
    assign accept  = InValid && InReady;

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == CW'(1)) begin
                    capture    = 1'b1;
                    next_state = HOLD;
                end
            end
            HOLD: begin
                if (OutReady) begin
                    next_state = InValid ? SETTLE : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            InA      <= '0;
            InB      <= '0;
            Product  <= '0;
            OutValid <= 1'b0;
        end else begin
            state <= next_state;
            if (accept) begin
                InA <= OpA;
                InB <= OpB;
                cnt <= CW'(SETTLE_CYCLES);
            end else if (state == SETTLE) begin
                cnt <= cnt - CW'(1);
            end
            if (capture) begin
                Product  <= MultOut;
                OutValid <= 1'b1;
            end else if ((state == HOLD) && OutReady) begin
                OutValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// tb/tb_mult_operand_sequencer.sv - directed self-checking bench for mult_operand_sequencer
module tb_mult_operand_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        InValid;
    logic        InReady;
    logic [31:0] OpA;
    logic [31:0] OpB;
    logic [31:0] InA;
    logic [31:0] InB;
    logic [63:0] MultOut;
    logic        OutValid;
    logic        OutReady;
    logic [63:0] Product;
    logic        Busy;

    int checks   = 0;
    int failures = 0;

    mult_operand_sequencer #(
        .INPUT_BIT_SIZE (32),
        .OUTPUT_BIT_SIZE(64),
        .SETTLE_CYCLES  (2)
    ) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .InValid (InValid),
        .InReady (InReady),
        .OpA     (OpA),
        .OpB     (OpB),
        .InA     (InA),
        .InB     (InB),
        .MultOut (MultOut),
        .OutValid(OutValid),
        .OutReady(OutReady),
        .Product (Product),
        .Busy    (Busy)
    );

    assign MultOut = 64'(InA) * 64'(InB);

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Reset    = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b0;
        OpA      = 32'h0;
        OpB      = 32'h0;

        // Reset held for three cycles with garbage offered on the inputs.
        OpA     = 32'h1234_5678;
        OpB     = 32'h9abc_def0;
        InValid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_ina", InA, 0);
            check("rst_inb", InB, 0);
            check("rst_product", Product, 0);
            check("rst_outvalid", OutValid, 0);
            check("rst_busy", Busy, 0);
            check("rst_inready", InReady, 0);
        end
        InValid = 1'b0;
        Reset   = 1'b1;
        #1;
        check("post_rst_inready", InReady, 1);
        check("post_rst_busy", Busy, 0);

        // First product.
        OpA     = 32'h0000_1111;
        OpB     = 32'h0000_0111;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("acc1_busy", Busy, 1);
        check("acc1_ina", InA, 32'h0000_1111);
        check("acc1_inb", InB, 32'h0000_0111);
        check("acc1_inready", InReady, 0);
        check("acc1_outvalid_e0", OutValid, 0);
        step();
        check("acc1_outvalid_e1", OutValid, 0);
        check("acc1_busy_e1", Busy, 1);
        step();
        check("acc1_outvalid_e2", OutValid, 1);
        check("acc1_product", Product, 64'h0000_0000_0012_3321);
        check("acc1_busy_e2", Busy, 1);

        // Stall in HOLD with a new pair offered.
        OpA      = 32'hdead_beef;
        OpB      = 32'hcafe_f00d;
        InValid  = 1'b1;
        OutReady = 1'b0;
        #1;
        check("stall_inready", InReady, 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_product", Product, 64'h0000_0000_0012_3321);
            check("stall_outvalid", OutValid, 1);
            check("stall_ina", InA, 32'h0000_1111);
            check("stall_inb", InB, 32'h0000_0111);
            check("stall_inready", InReady, 0);
        end

        // Back-to-back hand-off into a new accept.
        OpA      = 32'hffff_ffff;
        OpB      = 32'hffff_ffff;
        OutReady = 1'b1;
        #1;
        check("b2b_inready", InReady, 1);
        step();
        InValid  = 1'b0;
        OutReady = 1'b0;
        check("b2b_outvalid_e0", OutValid, 0);
        check("b2b_busy_e0", Busy, 1);
        check("b2b_ina", InA, 32'hffff_ffff);
        check("b2b_product_held", Product, 64'h0000_0000_0012_3321);
        step();
        check("b2b_outvalid_e1", OutValid, 0);
        check("b2b_busy_e1", Busy, 1);
        step();
        check("b2b_outvalid_e2", OutValid, 1);
        check("b2b_product", Product, 64'hffff_fffe_0000_0001);

        // Plain hand-off to IDLE; operands and product retained.
        OutReady = 1'b1;
        step();
        OutReady = 1'b0;
        check("handoff_outvalid", OutValid, 0);
        check("handoff_busy", Busy, 0);
        check("handoff_inready", InReady, 1);
        check("handoff_ina", InA, 32'hffff_ffff);
        check("handoff_product", Product, 64'hffff_fffe_0000_0001);

        // Reset in the middle of SETTLE.
        OpA     = 32'h0100_1111;
        OpB     = 32'h1000_0111;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("abort_busy_acc", Busy, 1);
        step();
        check("abort_outvalid_pre", OutValid, 0);
        Reset = 1'b0;
        #1;
        check("abort_busy", Busy, 0);
        check("abort_ina", InA, 0);
        check("abort_inb", InB, 0);
        check("abort_product", Product, 0);
        check("abort_inready", InReady, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_outvalid", OutValid, 0);
        end
        Reset = 1'b1;
        #1;
        check("abort_rel_inready", InReady, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_idle_outvalid", OutValid, 0);
            check("abort_idle_busy", Busy, 0);
        end

        // Zero operand.
        OpA     = 32'h0000_0000;
        OpB     = 32'h1000_0011;
        InValid = 1'b1;
        step();
        InValid = 1'b0;
        check("zero_inb", InB, 32'h1000_0011);
        step();
        check("zero_outvalid_e1", OutValid, 0);
        step();
        check("zero_outvalid_e2", OutValid, 1);
        check("zero_product", Product, 0);
        OutReady = 1'b1;
        step();
        check("zero_handoff_outvalid", OutValid, 0);
        check("zero_handoff_busy", Busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
